// File: rtl/lcd_read_engine.sv
// lcd_read_engine: 4-bit HD44780 read side (busy flag/AC or DDRAM data).
// Arbitrates for the LCD pins, pulses E twice per byte, optional BF polling.
module lcd_read_engine #(
  parameter int T_SETUP  = 2,
  parameter int T_EH     = 12,
  parameter int T_EL     = 50,
  parameter int POLL_MAX = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_busy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_timeout,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic       lcd_rd_act,
  input  logic [3:0] lcd_din,
  output logic [2:0] control
);

  localparam int CW = 17;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] REQ   = 4'd1;
  localparam logic [3:0] SET_H = 4'd2;
  localparam logic [3:0] EHI_H = 4'd3;
  localparam logic [3:0] ELO_H = 4'd4;
  localparam logic [3:0] SET_L = 4'd5;
  localparam logic [3:0] EHI_L = 4'd6;
  localparam logic [3:0] ELO_L = 4'd7;
  localparam logic [3:0] CHK   = 4'd8;
  localparam logic [3:0] DONE  = 4'd9;

  localparam logic [CW-1:0] SET_C  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EH_C   = CW'(T_EH - 1);
  localparam logic [CW-1:0] EL_C   = CW'(T_EL - 1);
  localparam logic [CW-1:0] PMAX_C = CW'(POLL_MAX - 1);

  logic [3:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] poll_cnt;
  logic          rs_l;
  logic          poll_l;
  logic [3:0]    hi;
  logic [3:0]    lo;
  logic          e;
  logic          rs_o;
  logic          rw;
  logic          cnt_zero;

  assign control  = {e, rs_o, rw};
  assign cnt_zero = (cnt == '0);

  // Sequencer: grant, two E pulses per byte, optional BF re-read, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      poll_cnt   <= '0;
      rs_l       <= 1'b0;
      poll_l     <= 1'b0;
      hi         <= 4'h0;
      lo         <= 4'h0;
      e          <= 1'b0;
      rs_o       <= 1'b0;
      rw         <= 1'b0;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      rd_data    <= 8'h00;
      bus_req    <= 1'b0;
      lcd_rd_act <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      if (!cnt_zero) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (rd_req) begin
          rs_l    <= rd_rs;
          poll_l  <= rd_poll;
          bus_req <= 1'b1;
          rd_busy <= 1'b1;
          state   <= REQ;
        end
        REQ: if (bus_gnt) begin
          lcd_rd_act <= 1'b1;
          rs_o       <= rs_l;
          rw         <= 1'b1;
          cnt        <= SET_C;
          state      <= SET_H;
        end
        SET_H: if (cnt_zero) begin
          e     <= 1'b1;
          cnt   <= EH_C;
          state <= EHI_H;
        end
        EHI_H: if (cnt_zero) begin
          hi    <= lcd_din;
          e     <= 1'b0;
          cnt   <= EL_C;
          state <= ELO_H;
        end
        ELO_H: if (cnt_zero) begin
          cnt   <= SET_C;
          state <= SET_L;
        end
        SET_L: if (cnt_zero) begin
          e     <= 1'b1;
          cnt   <= EH_C;
          state <= EHI_L;
        end
        EHI_L: if (cnt_zero) begin
          lo    <= lcd_din;
          e     <= 1'b0;
          cnt   <= EL_C;
          state <= ELO_L;
        end
        ELO_L: if (cnt_zero) state <= CHK;
        CHK: begin
          if (poll_l && !rs_l && hi[3] && (poll_cnt < PMAX_C)) begin
            poll_cnt <= poll_cnt + 1'b1;
            cnt      <= SET_C;
            state    <= SET_H;
          end else begin
            rd_data    <= {hi, lo};
            rd_valid   <= 1'b1;
            rd_timeout <= poll_l && hi[3];
            e          <= 1'b0;
            rs_o       <= 1'b0;
            rw         <= 1'b0;
            lcd_rd_act <= 1'b0;
            bus_req    <= 1'b0;
            poll_cnt   <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          rd_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
